// File: rtl/servant_uart_loader.sv
// Serial boot loader: receives an 8N1 UART stream, strips a 16-bit little-endian
// word-count header, packs payload bytes little-endian into 32-bit words and
// writes them over a Wishbone master port into consecutive RAM words.
module servant_uart_loader #(
  parameter int depth        = 256,
  parameter int aw           = $clog2(depth),
  parameter int CLKS_PER_BIT = 104,
  parameter int BASE_WORD    = 0
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic          i_uart_dat,
  output logic [aw-1:2] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic          i_wb_ack,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_frame_err,
  output logic          o_overrun
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [aw-3:0] BASE_ADR = (aw-2)'(BASE_WORD);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    LD_LEN0 = 2'd0,
    LD_LEN1 = 2'd1,
    LD_DATA = 2'd2,
    LD_DONE = 2'd3
  } ld_state_t;

  logic          rx_meta_r, rx_sync_r;
  rx_state_t     rx_state_r, rx_next_s;
  logic [CW-1:0] clk_cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    rx_shift_r;
  logic          byte_valid_s, frame_err_s;

  ld_state_t     ld_state_r, ld_next_s;
  logic [15:0]   count_r, written_r;
  logic [1:0]    lane_r;
  logic [23:0]   word_buf_r;
  logic [31:0]   wr_dat_r;
  logic [aw-3:0] adr_r;
  logic          cyc_r, busy_r, done_r, frame_err_r, overrun_r;
  logic          ack_s, word_done_s, bit_tick_s;

  assign ack_s       = cyc_r & i_wb_ack;
  assign word_done_s = (ld_state_r == LD_DATA) & byte_valid_s & (lane_r == 2'd3);
  assign bit_tick_s  = (rx_state_r == RX_DATA) & (clk_cnt_r == FULL_CNT);

  assign o_wb_adr    = adr_r;
  assign o_wb_dat    = wr_dat_r;
  assign o_wb_sel    = {4{cyc_r}};
  assign o_wb_we     = cyc_r;
  assign o_wb_cyc    = cyc_r;
  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_frame_err = frame_err_r;
  assign o_overrun   = overrun_r;

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= i_uart_dat;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receiver state register.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) rx_state_r <= RX_IDLE;
    else          rx_state_r <= rx_next_s;
  end

  // Receiver next state; bit sampling happens when the bit counter hits its target.
  always_comb begin
    rx_next_s    = rx_state_r;
    byte_valid_s = 1'b0;
    frame_err_s  = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (!rx_sync_r) rx_next_s = RX_START;
        else            rx_next_s = RX_IDLE;
      end
      RX_START: begin
        if (clk_cnt_r == HALF_CNT) begin
          if (rx_sync_r) rx_next_s = RX_IDLE;
          else           rx_next_s = RX_DATA;
        end else begin
          rx_next_s = RX_START;
        end
      end
      RX_DATA: begin
        if (bit_tick_s && (bit_idx_r == 3'd7)) rx_next_s = RX_STOP;
        else                                   rx_next_s = RX_DATA;
      end
      RX_STOP: begin
        if (clk_cnt_r == FULL_CNT) begin
          rx_next_s = RX_IDLE;
          if (rx_sync_r) byte_valid_s = 1'b1;
          else           frame_err_s  = 1'b1;
        end else begin
          rx_next_s = RX_STOP;
        end
      end
      default: rx_next_s = RX_IDLE;
    endcase
  end

  // Bit-period counter and LSB-first shift register.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      clk_cnt_r  <= {CW{1'b0}};
      bit_idx_r  <= 3'd0;
      rx_shift_r <= 8'd0;
    end else begin
      if ((rx_next_s != rx_state_r) || (rx_state_r == RX_IDLE) || bit_tick_s)
        clk_cnt_r <= {CW{1'b0}};
      else
        clk_cnt_r <= clk_cnt_r + CW'(1);
      if (rx_state_r == RX_IDLE) begin
        bit_idx_r <= 3'd0;
      end else if (bit_tick_s) begin
        bit_idx_r  <= bit_idx_r + 3'd1;
        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
      end
    end
  end

  // Loader state register.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) ld_state_r <= LD_LEN0;
    else          ld_state_r <= ld_next_s;
  end

  // Loader next state: header bytes, then payload until the last write is acked.
  always_comb begin
    ld_next_s = ld_state_r;
    case (ld_state_r)
      LD_LEN0: begin
        if (byte_valid_s) ld_next_s = LD_LEN1;
        else              ld_next_s = LD_LEN0;
      end
      LD_LEN1: begin
        if (byte_valid_s) begin
          if ({rx_shift_r, count_r[7:0]} == 16'd0) ld_next_s = LD_DONE;
          else                                     ld_next_s = LD_DATA;
        end else begin
          ld_next_s = LD_LEN1;
        end
      end
      LD_DATA: begin
        if (ack_s && ((written_r + 16'd1) == count_r)) ld_next_s = LD_DONE;
        else                                           ld_next_s = LD_DATA;
      end
      LD_DONE: ld_next_s = LD_DONE;
      default: ld_next_s = LD_LEN0;
    endcase
  end

  // Header capture, lane packing, Wishbone write register and sticky flags.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      count_r     <= 16'd0;
      written_r   <= 16'd0;
      lane_r      <= 2'd0;
      word_buf_r  <= 24'd0;
      wr_dat_r    <= 32'd0;
      adr_r       <= BASE_ADR;
      cyc_r       <= 1'b0;
      busy_r      <= 1'b1;
      done_r      <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (frame_err_s) frame_err_r <= 1'b1;
      if ((ld_state_r == LD_LEN0) && byte_valid_s) count_r[7:0]  <= rx_shift_r;
      if ((ld_state_r == LD_LEN1) && byte_valid_s) count_r[15:8] <= rx_shift_r;
      if ((ld_state_r == LD_DATA) && byte_valid_s) begin
        lane_r <= lane_r + 2'd1;
        case (lane_r)
          2'd0:    word_buf_r[7:0]   <= rx_shift_r;
          2'd1:    word_buf_r[15:8]  <= rx_shift_r;
          2'd2:    word_buf_r[23:16] <= rx_shift_r;
          default: word_buf_r        <= word_buf_r;
        endcase
      end
      // Acknowledge closes the current write; a new word may start only when idle.
      if (ack_s) begin
        cyc_r     <= 1'b0;
        adr_r     <= adr_r + (aw-2)'(1);
        written_r <= written_r + 16'd1;
      end
      if (word_done_s) begin
        if (cyc_r) begin
          overrun_r <= 1'b1;
        end else begin
          wr_dat_r <= {rx_shift_r, word_buf_r};
          cyc_r    <= 1'b1;
        end
      end
      busy_r <= (ld_next_s != LD_DONE);
      done_r <= (ld_next_s == LD_DONE);
    end
  end

endmodule

// File: tb/tb_servant_uart_loader.sv
// Bench for servant_uart_loader: two instances (base word 0 and 63) share the
// serial line; each has a one-cycle-ack RAM model. Expected writes come from a
// byte-list model of the framing rules.
module tb_servant_uart_loader;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart = 1'b1;
  logic ack0 = 1'b0, ack1 = 1'b0;
  logic [7:2] adr0, adr1;
  logic [31:0] dat0, dat1;
  logic [3:0] sel0, sel1;
  logic we0, we1, cyc0, cyc1, busy0, busy1, done0, done1;
  logic ferr0, ferr1, ovr0, ovr1;

  int n_assert = 0;
  int n_fail = 0;
  logic [42:0] wq0[$], wq1[$];
  int lq[$];
  int len0 = 0, len1 = 0;
  logic [7:0] pay[$];

  always #5 clk = ~clk;

  servant_uart_loader #(.depth(256), .CLKS_PER_BIT(CPB), .BASE_WORD(0)) dut0 (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_uart_dat(uart),
    .o_wb_adr(adr0), .o_wb_dat(dat0), .o_wb_sel(sel0), .o_wb_we(we0),
    .o_wb_cyc(cyc0), .i_wb_ack(ack0), .o_busy(busy0), .o_done(done0),
    .o_frame_err(ferr0), .o_overrun(ovr0));

  servant_uart_loader #(.depth(256), .CLKS_PER_BIT(CPB), .BASE_WORD(63)) dut1 (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_uart_dat(uart),
    .o_wb_adr(adr1), .o_wb_dat(dat1), .o_wb_sel(sel1), .o_wb_we(we1),
    .o_wb_cyc(cyc1), .i_wb_ack(ack1), .o_busy(busy1), .o_done(done1),
    .o_frame_err(ferr1), .o_overrun(ovr1));

  // RAM models: acknowledge one cycle after the cycle request.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
    end else begin
      ack0 <= cyc0 && !ack0;
      ack1 <= cyc1 && !ack1;
    end
  end

  // Record each acknowledged write and how many cycles its request lasted.
  always @(posedge clk) begin
    if (rst) begin
      len0 <= 0;
      len1 <= 0;
    end else begin
      if (cyc0) begin
        if (ack0) begin
          wq0.push_back({sel0, we0, adr0, dat0});
          lq.push_back(len0 + 1);
          len0 <= 0;
        end else len0 <= len0 + 1;
      end
      if (cyc1) begin
        if (ack1) begin
          wq1.push_back({sel1, we1, adr1, dat1});
          lq.push_back(len1 + 1);
          len1 <= 0;
        end else len1 <= len1 + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
    @(negedge clk);
    uart = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart = stop_bit;
    repeat (CPB) @(negedge clk);
    uart = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    if (check) begin
      chk("rst_cyc", {cyc0, cyc1, we0, we1}, 4'b0000);
      chk("rst_sel", {sel0, sel1}, 8'h00);
      chk("rst_dat", {dat0, dat1}, 64'h0);
      chk("rst_adr0", adr0, 6'd0);
      chk("rst_adr1", adr1, 6'd63);
      chk("rst_busy_done", {busy0, busy1, done0, done1}, 4'b1100);
      chk("rst_flags", {ferr0, ferr1, ovr0, ovr1}, 4'b0000);
    end
    rst = 1'b0;
    wq0.delete();
    wq1.delete();
    lq.delete();
    repeat (2) @(negedge clk);
  endtask

  // Send header + pay[], then compare both instances against the expected writes.
  task automatic run_load(input string tag, input int count, input bit do_rst);
    logic [42:0] exp0[$];
    logic [42:0] exp1[$];
    logic [31:0] d;
    int words, t;
    bit exp_done;
    if (do_rst) do_reset(0);
    words = pay.size() / 4;
    if (words > count) words = count;
    exp_done = (pay.size() / 4 >= count);
    for (int i = 0; i < words; i++) begin
      d = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
      exp0.push_back({4'hF, 1'b1, 6'(i % 64), d});
      exp1.push_back({4'hF, 1'b1, 6'((63 + i) % 64), d});
    end
    send_byte(count[7:0], 1'b1, 4);
    send_byte(count[15:8], 1'b1, 4);
    foreach (pay[i]) send_byte(pay[i], 1'b1, 2);
    if (exp_done) begin
      t = 0;
      while (!(done0 && done1) && t < 100) begin
        @(negedge clk);
        t++;
      end
    end else begin
      repeat (30) @(negedge clk);
    end
    chk({tag, "_done"}, {done0, done1}, {exp_done, exp_done});
    chk({tag, "_busy"}, {busy0, busy1}, {!exp_done, !exp_done});
    chk({tag, "_ovr"}, {ovr0, ovr1}, 2'b00);
    chk({tag, "_cyc_idle"}, {cyc0, cyc1}, 2'b00);
    chk({tag, "_nwr0"}, wq0.size(), exp0.size());
    chk({tag, "_nwr1"}, wq1.size(), exp1.size());
    for (int i = 0; i < exp0.size() && i < wq0.size(); i++)
      chk({tag, "_wr0"}, wq0[i], exp0[i]);
    for (int i = 0; i < exp1.size() && i < wq1.size(); i++)
      chk({tag, "_wr1"}, wq1[i], exp1[i]);
    foreach (lq[i]) chk({tag, "_cyclen"}, lq[i], 2);
  endtask

  initial begin
    bit seen;
    int cnt, nb;

    do_reset(1);

    // A single-cycle low pulse on an idle line is not a start bit.
    @(negedge clk) uart = 1'b0;
    @(negedge clk) uart = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_flags", {ferr0, ferr1, ovr0, ovr1}, 4'b0000);
    chk("glitch_state", {busy0, busy1, done0, done1}, 4'b1100);

    // Bad stop bit: byte dropped, loader stays on the first header byte.
    send_byte(8'h5A, 1'b0, 3 * CPB);
    chk("ferr_set", {ferr0, ferr1}, 2'b11);
    pay.delete();
    run_load("ferr_hdr", 0, 1'b0);
    chk("ferr_sticky", {ferr0, ferr1}, 2'b11);

    // Directed two-word load (covers wrap 63 -> 0 on the second instance).
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load("dir2", 2, 1'b1);
    chk("dir2_w0", wq0.size() > 0 ? wq0[0][31:0] : 32'h0, 32'h44332211);
    chk("dir2_w1", wq0.size() > 1 ? wq0[1][31:0] : 32'h0, 32'h88776655);

    // Zero count: done right after the header, payload ignored.
    pay.delete();
    run_load("zero", 0, 1'b1);
    for (int i = 0; i < 4; i++) pay.push_back(8'($urandom));
    run_load("zero_ign", 0, 1'b1);

    // Reset while a write is pending drops the cycle at once.
    do_reset(0);
    send_byte(8'h01, 1'b1, 4);
    send_byte(8'h00, 1'b1, 4);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 2);
    send_byte(8'($urandom), 1'b1, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = cyc0;
    end
    chk("midwr_seen", seen, 1'b1);
    rst = 1'b1;
    #1;
    chk("midwr_cyc", {cyc0, cyc1, we0, we1}, 4'b0000);
    chk("midwr_adr", {adr0, adr1}, {6'd0, 6'd63});
    chk("midwr_nowr", wq0.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wq0.delete();
    wq1.delete();
    lq.delete();
    repeat (2) @(negedge clk);
    pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load("fresh", 1, 1'b0);

    // Randomized complete loads.
    for (int r = 0; r < 4; r++) begin
      cnt = $urandom_range(1, 6);
      pay.delete();
      for (int i = 0; i < 4 * cnt; i++) pay.push_back(8'($urandom));
      run_load("rand", cnt, 1'b1);
    end

    // Partial final word: no write for it and loader keeps waiting.
    cnt = $urandom_range(2, 4);
    nb = 4 * (cnt - 1) + $urandom_range(1, 3);
    pay.delete();
    for (int i = 0; i < nb; i++) pay.push_back(8'($urandom));
    run_load("partial", cnt, 1'b1);

    // More words than the RAM holds: addresses wrap without error.
    pay.delete();
    for (int i = 0; i < 4 * 66; i++) pay.push_back(8'($urandom));
    run_load("wrap66", 66, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/servant_uart_loader.md
Name: servant_uart_loader

Overview:
- Serial boot loader sitting directly upstream of servant_ram, acting as a Wishbone master on the RAM's write port.
- Receives a raw UART stream, strips a 2-byte length header, packs payload bytes little-endian into 32-bit words and writes them into consecutive RAM words.
- Asserts done when the programmed word count has been written, so the CPU can be released from reset.

Parameters:
- depth, 256, RAM size in bytes; must match servant_ram depth.
- aw, $clog2(depth), byte address width.
- CLKS_PER_BIT, 104, i_wb_clk cycles per UART bit (12 MHz / 115200); minimum 4.
- BASE_WORD, 0, first word address written (aw-2 bits).

Ports:
- i_wb_clk  input  1  system clock; all logic on rising edge.
- i_wb_rst  input  1  reset, asynchronous, active-high.
- i_uart_dat  input  1  raw serial line (idle high, 8N1, LSB first), asynchronous to i_wb_clk.
- o_wb_adr  output  aw-2 (bits [aw-1:2])  word address to RAM.
- o_wb_dat  output  32  write data.
- o_wb_sel  output  4  byte enables, always 4'b1111 during a cycle.
- o_wb_we  output  1  write strobe, equal to o_wb_cyc.
- o_wb_cyc  output  1  bus cycle request.
- i_wb_ack  input  1  RAM acknowledge.
- o_busy  output  1  loader is accepting or writing data.
- o_done  output  1  all words written; sticky until reset.
- o_frame_err  output  1  sticky: stop bit sampled low.
- o_overrun  output  1  sticky: word completed while previous write still pending.

Behaviour:
- Reset (asynchronous, any state): all outputs 0, except o_wb_adr=BASE_WORD and o_busy=1. RX FSM goes to IDLE, loader FSM goes to LEN0, byte counters are cleared. A reset mid-frame or mid-write aborts the operation; o_wb_cyc drops immediately.
- Input sync: two-flop synchronizer on i_uart_dat. All RX logic uses the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronized line low.
  - START: sample at CLKS_PER_BIT/2. Low -> DATA. High (glitch) -> IDLE with no byte produced.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits shifted LSB first -> STOP.
  - STOP: sample after CLKS_PER_BIT. High -> one-cycle byte_valid pulse. Low -> set o_frame_err and discard the byte. Either way -> IDLE.
- Loader FSM states: LEN0, LEN1, DATA, DONE.
  - LEN0: byte -> count[7:0].
  - LEN1: byte -> count[15:8]. If count==0 -> DONE, else -> DATA.
  - DATA: bytes fill word lanes 0..3 in order (first byte -> [7:0]). On the 4th byte the word is latched into the write register.
  - DONE: o_done=1, o_busy=0, every later byte ignored.
- Write handshake:
  - The cycle after the 4th byte_valid, o_wb_cyc=o_wb_we=1 with o_wb_adr and o_wb_dat stable.
  - Held until i_wb_ack is sampled high; o_wb_cyc is deasserted in the cycle following the ack. With servant_ram (ack one cycle after cyc), each write occupies exactly 2 cycles.
  - i_wb_ack while o_wb_cyc=0 is ignored.
  - On ack: o_wb_adr increments and the written-word counter increments. When it equals count -> DONE.
- Overrun: if a new word completes while o_wb_cyc=1, set o_overrun, drop the new word, and leave address and counter unchanged. This cannot occur with CLKS_PER_BIT>=4 and a 1-cycle ack.
- Address wrap: o_wb_adr wraps modulo depth/4 (aw-2 bit arithmetic). Counts larger than depth/4 overwrite from BASE_WORD onward with no error.
- Partial word: if fewer than 4 payload bytes arrive, no write is issued and the loader waits indefinitely.
- Simultaneous byte_valid and ack in the same cycle: both are processed; byte lane filling is independent of the write register.

Test Plan:
- CLKS_PER_BIT=4, depth=256. Send 02 00 11 22 33 44 55 66 77 88 -> writes 0x44332211 @word0 and 0x88776655 @word1; each cyc lasts 2 cycles; o_done=1 after the 2nd ack; o_busy=0.
- Send 00 00 -> o_done=1 one cycle after the 2nd byte; no Wishbone cycle issued.
- Byte 0x5A with stop bit driven low -> o_frame_err=1, byte discarded, loader stays in LEN0; the following valid header is accepted normally.
- 1-cycle low pulse on i_uart_dat while idle -> no byte produced, no flags set.
- BASE_WORD=63, count=2 -> writes at word 63, then word 0 (wrap).
- Assert i_wb_rst while o_wb_cyc=1 -> o_wb_cyc=0 in the same cycle; after release, a fresh header is required.
